// File: rtl/serial_bus_arbiter.sv
// rtl/serial_bus_arbiter.sv - round-robin grant arbiter for a shared serial bus
module serial_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic                           trans_done,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           bus_busy,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam bit            WDOG_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [TW-1:0] timer;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          owner_req;

  // Round-robin search: first requester strictly above the pointer, wrapping around
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Walk from farthest to nearest so the nearest requester is the last (winning) write
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(ptr) + k) % NUM_MASTERS);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Current owner still holding its request line
  always_comb begin
    owner_req = req[grant_id];
  end

  // Grant FSM; the RELEASE cycle is the bus turnaround, so re-arbitration
  // happens on its exit edge, leaving exactly one free cycle between owners
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
      ptr         <= IW'(NUM_MASTERS - 1);
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE, RELEASE: begin
          if (pick_valid) begin
            state    <= OWNED;
            grant    <= NUM_MASTERS'(1) << pick_idx;
            grant_id <= pick_idx;
            bus_busy <= 1'b1;
            timer    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        OWNED: begin
          if (WDOG_EN && (timer != TIMER_MAX)) begin
            timer <= timer + TW'(1);
          end
          if (trans_done || !owner_req || (WDOG_EN && (timer == TIMER_LAST))) begin
            state       <= RELEASE;
            grant       <= '0;
            bus_busy    <= 1'b0;
            ptr         <= grant_id;
            // Only a pure watchdog expiry flags an error; completion and drop win over it
            timeout_err <= !trans_done && owner_req;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb/tb_serial_bus_arbiter.sv - randomized and directed check of serial_bus_arbiter against a reference model
module tb_serial_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         trans_done;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         bus_busy;
  logic         timeout_err;

  int total;
  int bad;

  // Reference model: who owns the bus, who owned it last, how long the owner has held it
  int m_owner;
  int m_last;
  int m_id;
  int m_age;
  bit m_terr;

  serial_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .trans_done  (trans_done),
    .grant       (grant),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_id    = 0;
    m_age   = 0;
    m_terr  = 1'b0;
  endtask

  // One bus cycle of the rules: owner ends on done, withdrawal, or the TO-th held cycle;
  // a free bus hands ownership to the next requester after the last owner
  task automatic model_step();
    m_terr = 1'b0;
    if (m_owner >= 0) begin
      if (trans_done || !req[m_owner] || (m_age + 1 == TO)) begin
        m_terr  = !trans_done && req[m_owner];
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c] && m_owner < 0) begin
          m_owner = c;
          m_id    = c;
          m_age   = 0;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    check({tag, ".grant"}, int'(grant), eg);
    check({tag, ".busy"}, int'(bus_busy), int'(m_owner >= 0));
    check({tag, ".terr"}, int'(timeout_err), int'(m_terr));
    if (m_owner >= 0) check({tag, ".id"}, int'(grant_id), m_id);
  endtask

  // Advance one clock: model follows the edge, outputs compared at the falling edge
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen_terr;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    req        = '0;
    trans_done = 1'b0;
    model_reset();

    #12;
    check("rst.grant", int'(grant), 0);
    check("rst.id", int'(grant_id), 0);
    check("rst.busy", int'(bus_busy), 0);
    check("rst.terr", int'(timeout_err), 0);
    @(negedge clk);
    reset = 1'b0;

    // Single requester
    req = 4'b0100;
    cyc("t1");
    check("t1.grant_c", int'(grant), 4);
    check("t1.id_c", int'(grant_id), 2);
    trans_done = 1'b1;
    cyc("t1d");
    trans_done = 1'b0;
    check("t1.free_c", int'(grant), 0);
    req = '0;
    cyc("t1i");

    // Full contention after reset: 0,1,2,3,0 with one free cycle each time
    do_reset();
    req = 4'b1111;
    cyc("t2");
    for (int i = 0; i < 5; i++) begin
      check("t2.order", int'(grant_id), i % N);
      check("t2.held", int'(bus_busy), 1);
      trans_done = 1'b1;
      cyc("t2r");
      trans_done = 1'b0;
      check("t2.gap", int'(bus_busy), 0);
      cyc("t2g");
    end
    req = '0;
    trans_done = 1'b1;
    cyc("t2e");
    trans_done = 1'b0;
    cyc("t2e");

    // Round-robin wrap: after master 2, {0,2} requesting picks 0
    req = 4'b0100;
    cyc("t3");
    trans_done = 1'b1;
    cyc("t3");
    trans_done = 1'b0;
    req = 4'b0101;
    cyc("t3w");
    check("t3.wrap", int'(grant_id), 0);
    req = '0;
    trans_done = 1'b1;
    cyc("t3e");
    trans_done = 1'b0;
    cyc("t3e");

    // Watchdog: grant lasts exactly TO cycles, error pulses once
    req = 4'b0010;
    cyc("t4");
    cnt = 0;
    seen_terr = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      if (j == TO) req = '0 | 4'b0010;
      cyc("t4w");
      cnt = j;
      if (!bus_busy) begin
        seen_terr = timeout_err;
        break;
      end
    end
    req = '0;
    check("t4.len", cnt, TO);
    check("t4.pulse", int'(seen_terr), 1);
    cyc("t4p");
    check("t4.pulse_end", int'(timeout_err), 0);

    // Completion on the expiry cycle: no error
    req = 4'b0010;
    cyc("t5");
    for (int j = 1; j < TO; j++) cyc("t5w");
    trans_done = 1'b1;
    cyc("t5x");
    trans_done = 1'b0;
    req = '0;
    check("t5.terr", int'(timeout_err), 0);
    check("t5.busy", int'(bus_busy), 0);
    cyc("t5e");

    // Owner withdrawal releases at the next edge
    req = 4'b1000;
    cyc("t6");
    cyc("t6");
    req = '0;
    cyc("t6d");
    check("t6.drop", int'(bus_busy), 0);
    cyc("t6d");

    // Reset in the middle of a grant drops it immediately, master 0 first afterwards
    req = 4'b0100;
    cyc("t6r");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6r.grant", int'(grant), 0);
    check("t6r.busy", int'(bus_busy), 0);
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    cyc("t6a");
    check("t6r.first", int'(grant_id), 0);
    req = '0;
    trans_done = 1'b1;
    cyc("t6e");
    trans_done = 1'b0;

    // Random traffic; the owner mostly keeps its request so watchdog expiries occur too
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
      req = r;
      trans_done = ($urandom_range(0, 6) == 0);
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
